// File: rtl/sm_irq_ctrl_pkg.sv
// Shared register-map constants for the schoolMIPS external interrupt controller.
// The CPU top decodes the same window, so both sides import these values.
package sm_irq_ctrl_pkg;

  // Word offsets inside the 16-byte register window (bAddr[3:2])
  localparam logic [1:0] IRQ_REG_PENDING = 2'd0;
  localparam logic [1:0] IRQ_REG_MASK    = 2'd1;
  localparam logic [1:0] IRQ_REG_EDGE    = 2'd2;
  localparam logic [1:0] IRQ_REG_VECTOR  = 2'd3;

  // Default byte base address of the window; the low nibble must stay zero
  localparam logic [31:0] IRQ_BASE_ADDR_DEFAULT = 32'h0000_7F00;

endpackage

// File: rtl/sm_irq_sync.sv
// Two-flop synchronizer for asynchronous interrupt lines, plus a third flop
// holding the previous synchronized value so that rising edges can be detected.
module sm_irq_sync #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  // Synchronizer chain: s1/s2 resolve metastability, s3 remembers the last s2
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/sm_irq_ctrl.sv
// Memory-mapped external interrupt controller for schoolMIPS.
// Bus handshake: there is no valid/ready; a write is accepted on the clock edge
// where bSel & bWe is high, and reads are combinational in the same cycle.
module sm_irq_ctrl
  import sm_irq_ctrl_pkg::*;
#(
  parameter int          IRQ_NUM   = 8,
  parameter logic [31:0] BASE_ADDR = IRQ_BASE_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] irqIn,
  input  logic [31:0]        bAddr,
  input  logic               bWe,
  input  logic [31:0]        bWData,
  output logic               bSel,
  output logic [31:0]        bRData,
  output logic               irqOut
);

  logic [IRQ_NUM-1:0] r_pending;
  logic [IRQ_NUM-1:0] r_mask;
  logic [IRQ_NUM-1:0] r_edge;

  logic [IRQ_NUM-1:0] w_sync;
  logic [IRQ_NUM-1:0] w_rise;
  logic [IRQ_NUM-1:0] w_wdata;
  logic [IRQ_NUM-1:0] w_active;
  logic [IRQ_NUM-1:0] w_pend_next;
  logic [1:0]         w_off;
  logic               w_wr_pend;
  logic               w_wr_mask;
  logic               w_wr_edge;
  logic               w_vec_valid;
  logic [4:0]         w_vec_idx;
  logic               w_unused;

  sm_irq_sync #(.W(IRQ_NUM)) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_async (irqIn),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  assign bSel      = (bAddr[31:4] == BASE_ADDR[31:4]);
  assign w_off     = bAddr[3:2];
  assign w_wdata   = bWData[IRQ_NUM-1:0];
  assign w_wr_pend = bSel & bWe & (w_off == IRQ_REG_PENDING);
  assign w_wr_mask = bSel & bWe & (w_off == IRQ_REG_MASK);
  assign w_wr_edge = bSel & bWe & (w_off == IRQ_REG_EDGE);
  assign w_active  = r_pending & r_mask;

  // Byte-lane bits and data bits above IRQ_NUM carry no meaning here
  assign w_unused = ^{bAddr[1:0], bWData[31:IRQ_NUM]};

  // Next PENDING per source: a mode flip clears, edge mode lets set beat W1C,
  // level mode simply follows the synchronized line
  always_comb begin
    w_pend_next = r_pending;
    for (int i = 0; i < IRQ_NUM; i++) begin
      if (w_wr_edge && (w_wdata[i] != r_edge[i])) begin
        w_pend_next[i] = 1'b0;
      end else if (r_edge[i]) begin
        if (w_rise[i]) begin
          w_pend_next[i] = 1'b1;
        end else if (w_wr_pend && w_wdata[i]) begin
          w_pend_next[i] = 1'b0;
        end
      end else begin
        w_pend_next[i] = w_sync[i];
      end
    end
  end

  // Register state and the registered request to the CPU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_edge    <= '0;
      irqOut    <= 1'b0;
    end else begin
      r_pending <= w_pend_next;
      irqOut    <= |w_active;
      if (w_wr_mask) r_mask <= w_wdata;
      if (w_wr_edge) r_edge <= w_wdata;
    end
  end

  // Priority encoder: lowest enabled pending index wins
  always_comb begin
    w_vec_valid = |w_active;
    w_vec_idx   = 5'd0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (w_active[i]) w_vec_idx = 5'(i);
    end
  end

  // Combinational read mux, zero outside the window
  always_comb begin
    bRData = 32'd0;
    if (bSel) begin
      case (w_off)
        IRQ_REG_PENDING: bRData = {{(32-IRQ_NUM){1'b0}}, r_pending};
        IRQ_REG_MASK:    bRData = {{(32-IRQ_NUM){1'b0}}, r_mask};
        IRQ_REG_EDGE:    bRData = {{(32-IRQ_NUM){1'b0}}, r_edge};
        IRQ_REG_VECTOR:  bRData = {w_vec_valid, 26'd0, w_vec_idx};
        default:         bRData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_irq_ctrl.sv
// Bench for sm_irq_ctrl: directed scenarios with fixed expectations, then a
// randomized run compared each cycle against a behavioural model.
module tb_sm_irq_ctrl;

  localparam logic [31:0] A_PEND = 32'h0000_7F00;
  localparam logic [31:0] A_MASK = 32'h0000_7F04;
  localparam logic [31:0] A_EDGE = 32'h0000_7F08;
  localparam logic [31:0] A_VEC  = 32'h0000_7F0C;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irqIn;
  logic [31:0] bAddr;
  logic        bWe;
  logic [31:0] bWData;
  logic        bSel;
  logic [31:0] bRData;
  logic        irqOut;

  int n_vec;
  int n_err;

  sm_irq_ctrl #(.IRQ_NUM(8), .BASE_ADDR(32'h0000_7F00)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .irqIn  (irqIn),
    .bAddr  (bAddr),
    .bWe    (bWe),
    .bWData (bWData),
    .bSel   (bSel),
    .bRData (bRData),
    .irqOut (irqOut)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // m_hist[a] is the raw input sampled a+1 edges ago; the controller acts on
  // the value seen two edges back and compares it with the one three back.
  logic [7:0] m_pend, m_mask, m_edge;
  logic       m_irq;
  logic [7:0] m_hist [0:2];

  function automatic logic in_window(input logic [31:0] a);
    return a[31:4] == 28'h0000_7F0;
  endfunction

  function automatic logic [7:0] pend_rule(input logic [7:0] pend, input logic [7:0] mode,
                                           input logic [7:0] seen, input logic [7:0] seen_before,
                                           input logic w1c, input logic mode_wr,
                                           input logic [7:0] wd);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (mode_wr && (wd[i] != mode[i]))   r[i] = 1'b0;
      else if (!mode[i])                   r[i] = seen[i];
      else if (seen[i] && !seen_before[i]) r[i] = 1'b1;
      else if (w1c && wd[i])               r[i] = 1'b0;
      else                                 r[i] = pend[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [7:0] act;
    if (!in_window(a)) return 32'd0;
    case (a[3:2])
      2'd0: return {24'd0, m_pend};
      2'd1: return {24'd0, m_mask};
      2'd2: return {24'd0, m_edge};
      default: begin
        act = m_pend & m_mask;
        for (int i = 0; i < 8; i++) if (act[i]) return 32'h8000_0000 | i;
        return 32'd0;
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend    <= '0;
      m_mask    <= '0;
      m_edge    <= '0;
      m_irq     <= 1'b0;
      m_hist[0] <= '0;
      m_hist[1] <= '0;
      m_hist[2] <= '0;
    end else begin
      m_irq  <= |(m_pend & m_mask);
      m_pend <= pend_rule(m_pend, m_edge, m_hist[1], m_hist[2],
                          in_window(bAddr) && bWe && bAddr[3:2] == 2'd0,
                          in_window(bAddr) && bWe && bAddr[3:2] == 2'd2,
                          bWData[7:0]);
      if (in_window(bAddr) && bWe && bAddr[3:2] == 2'd1) m_mask <= bWData[7:0];
      if (in_window(bAddr) && bWe && bAddr[3:2] == 2'd2) m_edge <= bWData[7:0];
      m_hist[0] <= irqIn;
      m_hist[1] <= m_hist[0];
      m_hist[2] <= m_hist[1];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after the write edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bAddr  = a;
    bWData = d;
    bWe    = 1'b1;
    @(negedge clk);
    bWe    = 1'b0;
    bWData = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bAddr = a;
    bWe   = 1'b0;
    #1;
    d = bRData;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [31:0] d;
    logic [31:0] addrs [4];
    addrs = '{A_PEND, A_MASK, A_EDGE, A_VEC};
    rst_n = 1'b0;
    irqIn = '0;
    tick(3);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (irqOut !== 1'b0) begin n_err++; $display("FAIL reset_irqOut got=%b want=0", irqOut); end
    foreach (addrs[k]) begin
      bus_read(addrs[k], d);
      n_vec++;
      if (d !== 32'd0) begin n_err++; $display("FAIL reset_read_%h got=%h want=0", addrs[k], d); end
    end
    bus_read(32'h0000_7F10, d);
    n_vec++;
    if (bSel !== 1'b0 || d !== 32'd0) begin
      n_err++; $display("FAIL reset_outside got bSel=%b data=%h want bSel=0 data=0", bSel, d);
    end
    tick(1);
  endtask

  task automatic test_edge_request;
    logic [31:0] d;
    bus_write(A_MASK, 32'h04);
    bus_write(A_EDGE, 32'h04);
    irqIn[2] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      #1;
      n_vec++;
      if (irqOut !== (e == 4)) begin
        n_err++; $display("FAIL edge_latency edge=%0d got=%b want=%b", e, irqOut, e == 4);
      end
      if (e == 3) irqIn[2] = 1'b0;
    end
    bus_read(A_PEND, d);
    n_vec++;
    if (d !== 32'h04) begin n_err++; $display("FAIL edge_pending got=%h want=00000004", d); end
    bus_read(A_VEC, d);
    n_vec++;
    if (d !== 32'h8000_0002) begin n_err++; $display("FAIL edge_vector got=%h want=80000002", d); end
    tick(1);
    bus_write(A_PEND, 32'h04);
    bus_read(A_PEND, d);
    n_vec++;
    if (d !== 32'd0 || irqOut !== 1'b1) begin
      n_err++; $display("FAIL edge_w1c got pend=%h irq=%b want pend=0 irq=1", d, irqOut);
    end
    tick(1);
    #1;
    n_vec++;
    if (irqOut !== 1'b0) begin n_err++; $display("FAIL edge_w1c_drop got=%b want=0", irqOut); end
  endtask

  task automatic test_level_request;
    logic [31:0] d;
    tick(1);
    bus_write(A_EDGE, 32'h00);
    bus_write(A_MASK, 32'h01);
    irqIn[0] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      #1;
      if (e >= 3) begin
        n_vec++;
        if (irqOut !== (e == 4)) begin
          n_err++; $display("FAIL level_latency edge=%0d got=%b want=%b", e, irqOut, e == 4);
        end
      end
    end
    tick(1);
    bus_write(A_PEND, 32'h01);
    bus_read(A_PEND, d);
    n_vec++;
    if (d !== 32'h01) begin n_err++; $display("FAIL level_w1c_ignored got=%h want=00000001", d); end
    irqIn[0] = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      #1;
      if (e >= 3) begin
        n_vec++;
        if (irqOut !== (e != 4)) begin
          n_err++; $display("FAIL level_drop edge=%0d got=%b want=%b", e, irqOut, e != 4);
        end
      end
    end
  endtask

  task automatic test_priority_mask;
    logic [31:0] d;
    tick(1);
    bus_write(A_EDGE, 32'hFF);
    bus_write(A_MASK, 32'h20);
    irqIn = 8'h28;
    tick(5);
    bus_read(A_VEC, d);
    n_vec++;
    if (d !== 32'h8000_0005 || irqOut !== 1'b1) begin
      n_err++; $display("FAIL prio_masked got vec=%h irq=%b want vec=80000005 irq=1", d, irqOut);
    end
    tick(1);
    bus_write(A_MASK, 32'h28);
    bus_read(A_VEC, d);
    n_vec++;
    if (d !== 32'h8000_0003) begin n_err++; $display("FAIL prio_unmasked got=%h want=80000003", d); end
    tick(1);
    #1;
    n_vec++;
    if (irqOut !== 1'b1) begin n_err++; $display("FAIL prio_irq_hold got=%b want=1", irqOut); end
    irqIn = 8'h00;
    bus_write(A_PEND, 32'hFF);
    tick(1);
    bus_read(A_VEC, d);
    n_vec++;
    if (d !== 32'd0 || irqOut !== 1'b0) begin
      n_err++; $display("FAIL prio_clear got vec=%h irq=%b want vec=0 irq=0", d, irqOut);
    end
    tick(1);
  endtask

  task automatic test_collision;
    logic [31:0] d;
    bus_write(A_MASK, 32'h02);
    bus_read(A_PEND, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL coll_pre got=%h want=0", d); end
    tick(1);
    irqIn[1] = 1'b1;
    tick(2);
    bus_write(A_PEND, 32'h02);
    bus_read(A_PEND, d);
    n_vec++;
    if (d !== 32'h02) begin n_err++; $display("FAIL coll_set_wins got=%h want=00000002", d); end
    tick(1);
    bus_write(A_EDGE, 32'hFD);
    bus_read(A_PEND, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL coll_mode_flip got=%h want=0", d); end
    irqIn[1] = 1'b0;
    tick(4);
    bus_write(A_EDGE, 32'hFF);
    bus_write(A_PEND, 32'hFF);
    tick(2);
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    bus_write(A_MASK, 32'h01);
    bus_write(A_EDGE, 32'h01);
    irqIn[0] = 1'b1;
    tick(5);
    #1;
    n_vec++;
    if (irqOut !== 1'b1) begin n_err++; $display("FAIL areset_pre got=%b want=1", irqOut); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (irqOut !== 1'b0) begin n_err++; $display("FAIL areset_irq got=%b want=0", irqOut); end
    bus_read(A_MASK, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL areset_mask got=%h want=0", d); end
    bus_read(A_EDGE, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL areset_edge got=%h want=0", d); end
    bus_read(A_PEND, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL areset_pend got=%h want=0", d); end
    irqIn = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] want;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) irqIn = 8'($urandom);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = {28'h0000_7F0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      bAddr  = a;
      bWe    = ($urandom_range(0, 3) == 0);
      bWData = $urandom;
      #1;
      want = exp_read(a);
      n_vec++;
      if (bSel !== in_window(a) || bRData !== want || irqOut !== m_irq) begin
        n_err++;
        $display("FAIL rand_cycle%0d addr=%h got sel=%b rd=%h irq=%b want sel=%b rd=%h irq=%b",
                 c, a, bSel, bRData, irqOut, in_window(a), want, m_irq);
      end
      @(negedge clk);
    end
    bWe = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    irqIn  = '0;
    bAddr  = 32'd0;
    bWe    = 1'b0;
    bWData = 32'd0;
    @(negedge clk);
    test_reset();
    test_edge_request();
    test_level_request();
    test_priority_mask();
    test_collision();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sm_irq_ctrl.md
Name: sm_irq_ctrl

Overview:
- Memory-mapped external interrupt controller for schoolMIPS. It sits on the CPU data-memory bus (dmAddr/dmWe/dmWData/dmRData) alongside data RAM.
- It synchronizes IRQ_NUM asynchronous interrupt lines, latches edge- or level-mode requests, and applies a software mask.
- It drives a single registered request into the CPU, routed to cp0_ExcIP[4], the external-interrupt slot next to the timer bit.
- Software reads a priority vector to find the source, and clears edge-mode requests with write-1-to-clear.

Parameters:
- IRQ_NUM, 8: number of interrupt sources, legal range 1..31.
- BASE_ADDR, 32'h0000_7F00: byte base address of the 16-byte register window; bits [3:0] must be 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- irqIn  in  IRQ_NUM  raw external interrupt lines, asynchronous, active-high
- bAddr  in  32  data bus byte address (from dmAddr)
- bWe  in  1  data bus write enable (from dmWe)
- bWData  in  32  data bus write data (from dmWData)
- bSel  out  1  address hits the window; top-level read mux uses it to select bRData
- bRData  out  32  register read data, combinational
- irqOut  out  1  registered interrupt request to the CPU

Behaviour:
- One clock. Reset is asynchronous and active-low: all flops clear immediately when rst_n=0. Outputs after reset: irqOut=0; bRData follows address decode with all registers zero.
- Decode: bSel = (bAddr[31:4] == BASE_ADDR[31:4]). The offset is bAddr[3:2]; bAddr[1:0] is ignored.
- Register map:
  - 0x0 PENDING: read; write-1-to-clear, effective only in edge mode.
  - 0x4 MASK: read/write, 1 = enabled.
  - 0x8 EDGE: read/write, 1 = rising-edge mode, 0 = level mode.
  - 0xC VECTOR: read-only. Bit31 = valid; bits[4:0] = lowest index i with PENDING[i] & MASK[i]; all other bits 0.
- Unused upper bits (>= IRQ_NUM) read 0 and ignore writes. bRData = 0 when bSel=0. Writes to VECTOR are ignored.
- Reads are combinational in the same cycle, matching the single-cycle CPU. Writes take effect at the next clk edge when bSel & bWe.
- Synchronizer: each irqIn bit passes through 2 flops (s1, s2), reset 0. A third flop s3 holds the previous s2 value. rise = s2 & ~s3.
- PENDING[i] update at each clk edge:
  - Edge mode: set on rise[i]. Otherwise cleared if a W1C write has bWData[i]=1. Otherwise held. Set wins over a same-cycle clear.
  - Level mode: PENDING[i] <= s2[i]. W1C has no effect.
- Mode change: a write to EDGE that flips bit i clears PENDING[i] in that same edge, and this overrides any set.
- irqOut <= |(PENDING & MASK), registered.
- Latency from irqIn rising (sampled at edge 0) with MASK set: s1 at edge 1, s2 at edge 2, PENDING at edge 3, irqOut at edge 4. This holds in both modes.
- Masking changes reach irqOut one edge after the MASK write.
- Level-mode deassertion: irqOut falls 4 edges after irqIn falls.
- Edge-mode deassertion: irqOut falls one edge after the W1C write, unless a new rise coincides with the write.
- A pulse shorter than one clk period may be missed; sources must hold for at least 2 cycles.
- A held high input in edge mode produces exactly one PENDING set.
- Priority: index 0 is highest. VECTOR valid=0 implies bits[4:0]=0.
- Reset mid-operation: pending requests are lost, mask and mode return to 0, and irqOut drops asynchronously.

Decomposition:
- Shared settings header holds the register offsets (IRQ_REG_PENDING=2'd0, IRQ_REG_MASK=2'd1, IRQ_REG_EDGE=2'd2, IRQ_REG_VECTOR=2'd3) and the default BASE_ADDR. The CPU top uses the same constants.
- One sub-module, sm_irq_sync: a parameterized-width 2-flop synchronizer plus the previous-value flop. It outputs s2 and rise.
- The priority encoder stays inline in sm_irq_ctrl.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, irqIn=0. Expect irqOut=0; reads of 0x7F00/04/08/0C return 0; bSel=0 at 0x7F10.
2. Edge request: write MASK=0x04, EDGE=0x04; pulse irqIn[2] high for 3 cycles. Expect irqOut=1 exactly 4 edges after the rise; PENDING=0x04; VECTOR=0x8000_0002. Then W1C 0x04: irqOut=0 next edge, PENDING=0.
3. Level request: MASK=0x01, EDGE=0; hold irqIn[0] high. Expect irqOut=1 at edge 4. W1C 0x01 leaves PENDING=0x01. Drop irqIn: irqOut=0 after 4 edges.
4. Priority and mask: edge mode on all bits; raise irqIn[5] and irqIn[3] together with MASK=0x20. Expect VECTOR=0x8000_0005. Write MASK=0x28: VECTOR=0x8000_0003, irqOut stays 1.
5. Collision: in edge mode, issue W1C of bit 1 in the same cycle as rise[1]. Expect PENDING[1]=1 afterwards. Flip EDGE[1] while pending: PENDING[1]=0.
6. Async reset mid-request: with irqOut=1, pulse rst_n low between clock edges. Expect irqOut=0 immediately and MASK/EDGE/PENDING=0.
